// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_e;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

  // Number of instruction-RAM words addressable with a word address of the given width.
  function automatic logic [31:0] ramWords(input int unsigned waWidth);
    return 32'd1 << waWidth;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word packer shared by the header and data phases.
// The first byte of a group lands in bits 7:0; the group closes on index last_i.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  last_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [31:0] merged;
  logic        lastByte;

  // Insert the incoming byte at the current index and advance or wrap the index.
  always_comb begin
    merged              = word_q;
    merged[8*idx_q +: 8] = byte_i;
    lastByte            = byte_valid_i && (idx_q == last_i);
    word_o              = merged;
    word_valid_o        = lastByte;
    idx_d               = idx_q;
    word_d              = word_q;
    if (byte_valid_i) begin
      word_d = merged;
      idx_d  = lastByte ? 2'd0 : idx_q + 2'd1;
    end
  end

  // Byte index and partially assembled word; cleared so a reset drops any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: pops bytes from the UART RX buffer, reads a
// 32-bit little-endian word count, then writes that many words to
// consecutive instruction-RAM addresses and raises done.
// Optional feature macro PROG_LOADER_CHECKSUM_EN: sends an 8-bit wrap-around
// sum of the data bytes to the UART TX buffer once, just before done.
module prog_loader
  import loader_pkg::*;
#(
  parameter int MEM = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     rdata,
  input  logic           rx_ready,
  output logic           next,
  output logic           we,
  output logic [MEM-3:0] waddr,
  output logic [31:0]    wdata,
  output logic           done,
  output logic           err,
  output logic [7:0]     sdata,
  output logic           tx_valid
);

  localparam int WA = MEM - 2;
  localparam logic [WA-1:0] ADDR_ONE = 1;

  state_e          state_q, state_d;
  logic            nextPrev_q;
  logic [31:0]     count_q, count_d;
  logic [31:0]     wordCnt_q, wordCnt_d;
  logic [WA-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            accept;
  logic [1:0]      lastIdx;
  logic [31:0]     word;
  logic            wordValid;

  // A byte is taken only while loading, and never two cycles in a row so the RX head can advance.
  always_comb begin
    accept  = (state_q == HDR || state_q == DATA) && rx_ready && !nextPrev_q;
    lastIdx = (state_q == HDR) ? 2'(HDR_BYTES - 1) : 2'(BYTES_PER_WORD - 1);
  end

  word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (accept),
    .byte_i       (rdata),
    .last_i       (lastIdx),
    .word_o       (word),
    .word_valid_o (wordValid)
  );

  // Next-state logic: header decode, one write per packed word, and the end-of-load decision.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wordCnt_d = wordCnt_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    case (state_q)
      HDR: begin
        if (wordValid) begin
          count_d = word;
          if (word == 32'd0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else if (word > ramWords(WA)) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (wordValid) begin
          we_d    = 1'b1;
          wdata_d = word;
        end
        if (we_q) begin
          addr_d    = addr_q + ADDR_ONE;
          wordCnt_d = wordCnt_q + 32'd1;
          if (wordCnt_q == count_q - 32'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
      CSUM: begin
        state_d = DONE;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State, counters and the registered RAM write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HDR;
      nextPrev_q <= 1'b0;
      count_q    <= 32'd0;
      wordCnt_q  <= 32'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      nextPrev_q <= accept;
      count_q    <= count_d;
      wordCnt_q  <= wordCnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
    end
  end

  assign next  = accept;
  assign we    = we_q;
  assign waddr = addr_q;
  assign wdata = wdata_q;
  assign done  = (state_q == DONE);
  assign err   = (state_q == ERR);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  // Running sum of data bytes only; the header does not contribute.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= 8'd0;
    end else if (accept && state_q == DATA) begin
      csum_q <= csum_q + rdata;
    end
  end

  assign tx_valid = (state_q == CSUM);
  assign sdata    = tx_valid ? csum_q : 8'h00;
`else
  assign tx_valid = 1'b0;
  assign sdata    = 8'h00;
`endif

endmodule
